// File: rtl/sync_fifo_if.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_if
// Brief    : Write/read handshake and status bundle for sync_fifo.
// Revision : 1.0 - initial release
// ============================================================================
interface sync_fifo_if #(
    parameter int DATA_W = 16
);
    logic              i_wr;
    logic              i_rd;
    logic [DATA_W-1:0] i_data;
    logic [DATA_W-1:0] o_data;
    logic              o_full;
    logic              o_empty;

    modport master (
        output i_wr, i_rd, i_data,
        input  o_data, o_full, o_empty
    );

    modport slave (
        input  i_wr, i_rd, i_data,
        output o_data, o_full, o_empty
    );
endinterface
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Brief    : Single-clock FIFO with registered read data and count-based flags.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8
) (
    input  wire logic  i_clk,
    input  wire logic  i_rstn,
    sync_fifo_if.slave bus
);
    localparam int            AW         = $clog2(DEPTH);
    localparam logic [AW:0]   c_CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   c_CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] c_PTR_ONE  = AW'(1);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;
    logic [DATA_W-1:0] r_data;

    logic w_full;
    logic w_empty;
    logic w_rd_acc;
    logic w_wr_acc;

    assign w_full   = (r_count == c_CNT_FULL);
    assign w_empty  = (r_count == '0);
    assign w_rd_acc = bus.i_rd && !w_empty;
    // A full FIFO still takes a write when a read frees a slot on the same edge.
    assign w_wr_acc = bus.i_wr && (!w_full || w_rd_acc);

    always_ff @(posedge i_clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= bus.i_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_data   <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
                r_data   <= r_mem[r_rd_ptr];
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    assign bus.o_data  = r_data;
    assign bus.o_full  = w_full;
    assign bus.o_empty = w_empty;
endmodule
`default_nettype wire

// File: tb/tb_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_sync_fifo
// Brief    : Scoreboard bench for sync_fifo against a queue-based reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sync_fifo;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 8;

    typedef struct {
        logic [DATA_W-1:0] d;
        logic              f;
        logic              e;
    } exp_t;

    logic clk;
    logic rstn;
    int   checks   = 0;
    int   failures = 0;

    logic [DATA_W-1:0] m_q [$];
    logic [DATA_W-1:0] m_data;
    exp_t              exp_q [$];
    exp_t              m_e;

    sync_fifo_if #(.DATA_W(DATA_W)) bus ();

    sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .i_clk  (clk),
        .i_rstn (rstn),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock edge of stimulus; the reference decides acceptance from queue occupancy.
    task automatic step(input logic wr, input logic rd, input logic [DATA_W-1:0] d);
        bit rd_ok;
        bit wr_ok;
        bus.i_wr   = wr;
        bus.i_rd   = rd;
        bus.i_data = d;
        @(posedge clk);
        rd_ok = rd && (m_q.size() > 0);
        wr_ok = wr && ((m_q.size() < DEPTH) || rd_ok);
        if (rd_ok) m_data = m_q.pop_front();
        if (wr_ok) m_q.push_back(d);
        exp_q.push_back('{d: m_data, f: (m_q.size() == DEPTH), e: (m_q.size() == 0)});
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1 rstn = 1'b0;
        m_q.delete();
        m_data = '0;
        #1;
        chk("rst_data",  bus.o_data,  '0);
        chk("rst_full",  {15'd0, bus.o_full},  16'd0);
        chk("rst_empty", {15'd0, bus.o_empty}, 16'd1);
        @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            m_e = exp_q.pop_front();
            chk("o_data",  bus.o_data, m_e.d);
            chk("o_full",  {15'd0, bus.o_full},  {15'd0, m_e.f});
            chk("o_empty", {15'd0, bus.o_empty}, {15'd0, m_e.e});
        end
    end

    initial begin
        int pw;
        int pr;
        rstn       = 1'b0;
        bus.i_wr   = 1'b0;
        bus.i_rd   = 1'b0;
        bus.i_data = '0;
        m_data     = '0;
        #1;
        chk("por_data",  bus.o_data, '0);
        chk("por_full",  {15'd0, bus.o_full},  16'd0);
        chk("por_empty", {15'd0, bus.o_empty}, 16'd1);
        @(posedge clk);
        #1 rstn = 1'b1;

        step(1, 0, 16'd3);
        step(0, 1, 16'd0);
        step(1, 0, 16'd4);
        step(0, 1, 16'd0);

        for (int i = 1; i <= 10; i++) step(1, 0, 16'(i));
        for (int i = 0; i < 12; i++)  step(0, 1, 16'd0);
        step(1, 0, 16'd1);
        step(0, 1, 16'd0);

        // Write and read together on an empty FIFO: only the write lands.
        step(1, 1, 16'h00aa);
        step(0, 1, 16'd0);

        for (int i = 0; i < DEPTH; i++) step(1, 0, 16'(16'h100 + i));
        for (int i = 0; i < 12; i++)    step(1, 1, 16'(16'h200 + i));
        for (int i = 0; i < 10; i++)    step(0, 1, 16'd0);

        for (int i = 0; i < 5; i++) step(1, 0, 16'(16'h300 + i));
        do_reset();
        step(0, 1, 16'd0);
        step(1, 1, 16'h0bee);
        step(0, 1, 16'd0);

        for (int ph = 0; ph < 6; ph++) begin
            pw = (ph % 3 == 0) ? 80 : (ph % 3 == 1) ? 20 : 50;
            pr = (ph % 3 == 0) ? 30 : (ph % 3 == 1) ? 80 : 50;
            for (int i = 0; i < 300; i++) begin
                step(($urandom_range(0, 99) < pw), ($urandom_range(0, 99) < pr), 16'($urandom));
            end
        end
        do_reset();
        for (int i = 0; i < 200; i++) begin
            step(($urandom_range(0, 99) < 60), ($urandom_range(0, 99) < 60), 16'($urandom));
        end

        bus.i_wr = 1'b0;
        bus.i_rd = 1'b0;
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
